coord_pair_scheduler: RTL and testbench
=======================================

// Module: coord_pair_scheduler
// PURPOSE
// Sequences the coordinate-computation datapath over one conv tile. Walks every
// (weight chunk, activation chunk) pair, weight-major, and issues chunk addresses,
// active lane count and index-restart strobes under a valid/ready handshake.
// Sits between the tile controller (start/done) and the compressed-index buffers
// that feed coordinatecomputation.
// PARAMETERS
// CNT_W     16  width of chunk counts and chunk addresses
// PIPE_LAT  1   cycles from pair accept to coordinates valid in coordinatecomputation
// PORTS
// clk           in   1      clock
// reset         in   1      synchronous, active-high reset
// start         in   1      one-cycle pulse; sampled only in IDLE
// bitwidth      in   4      1=16 lanes, 2=8 lanes, 3=4 lanes; other values illegal
// num_w_chunks  in   CNT_W  weight chunks in tile
// num_a_chunks  in   CNT_W  activation chunks in tile
// cc_ready      in   1      downstream accepts pair this cycle
// cc_valid      out  1      pair presented
// cc_w_addr     out  CNT_W  weight chunk address
// cc_a_addr     out  CNT_W  activation chunk address
// cc_lanes      out  5      active lanes (16/8/4), latched at start
// cc_w_restart  out  1      first pair of tile: clear running weight index
// cc_a_restart  out  1      first pair of each weight chunk: clear running activation index
// busy          out  1      high from start accept until done pulse inclusive
// done          out  1      one-cycle pulse at tile end
// cfg_err       out  1      sticky; set on start with illegal bitwidth; cleared by next legal start
// stall_cycles  out  32     cycles with cc_valid && !cc_ready (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0. Reset mid-tile aborts, no done.
// - FSM: IDLE -> ISSUE (legal start, both counts >0); IDLE -> DONE (legal start, a count ==0);
//   IDLE stays (illegal bitwidth: cfg_err<=1, busy stays 0); ISSUE -> DRAIN on last pair
//   accept; DRAIN waits PIPE_LAT cycles -> DONE; DONE -> IDLE (done=1 that cycle).
// - Config (bitwidth, counts, lanes) latched on start accept; later input changes ignored.
// - ISSUE: cc_valid=1 every cycle. Accept = cc_valid && cc_ready. On accept a_addr++;
//   when a_addr==num_a-1, a_addr<=0 and w_addr++. Last pair: w=num_w-1, a=num_a-1.
// - Outputs (addr, lanes, restart strobes) held stable while cc_valid && !cc_ready.
// - cc_w_restart=1 only while presenting (0,0); cc_a_restart=1 while a_addr==0.
// - First cc_valid the cycle after start accept; zero bubbles under continuous ready:
//   tile takes 1 + num_w*num_a + PIPE_LAT + 1 cycles, start to done inclusive.
// - Address counters CNT_W bits; never wrap inside a tile (count <= 2^CNT_W-1).
// - start during busy ignored; start in DONE cycle ignored.
// - cc_valid never asserted outside ISSUE; cc_ready ignored outside ISSUE.
// CONFIGURATION
// - SCHED_PERF_CNT_EN defined: stall_cycles counts cycles with cc_valid && !cc_ready,
//   cleared on start accept and reset, saturates at 2^32-1, holds after done.
// - Undefined: no counter logic; stall_cycles tied to 0.
// TESTING
// - bw=1, W=2, A=3, ready=1: 6 pairs (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), lanes=16, done cycle 9.
// - bw=2, W=1, A=2, ready low 3 cycles on pair (0,1): outputs held, lanes=8,
//   stall_cycles=3 (macro on) / 0 (off).
// - bw=5 start: cfg_err=1, busy=0, no cc_valid; then bw=3 start: cfg_err=0, lanes=4.
// - W=4, A=0: no cc_valid, busy 2 cycles, done pulse, no restart strobes.
// - reset asserted mid-tile at pair (1,0): next cycle all outputs 0, IDLE, no done;
//   new start runs full tile from (0,0) with cc_w_restart=1.
// - start pulsed while busy and counts changed mid-tile: pair sequence unchanged.

Source files
------------

// File: rtl/coord_pair_scheduler.sv
// Walks every (weight chunk, activation chunk) pair of a conv tile, weight-major,
// under valid/ready. Optional stall counter: define SCHED_PERF_CNT_EN.
module coord_pair_scheduler #(
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       bitwidth,
    input  logic [CNT_W-1:0] num_w_chunks,
    input  logic [CNT_W-1:0] num_a_chunks,
    input  logic             cc_ready,
    output logic             cc_valid,
    output logic [CNT_W-1:0] cc_w_addr,
    output logic [CNT_W-1:0] cc_a_addr,
    output logic [4:0]       cc_lanes,
    output logic             cc_w_restart,
    output logic             cc_a_restart,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [31:0]      stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DRAIN_W    = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
    localparam int DRAIN_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   num_w_q;
    logic [CNT_W-1:0]   num_a_q;
    logic [CNT_W-1:0]   w_addr;
    logic [CNT_W-1:0]   a_addr;
    logic [4:0]         lanes_q;
    logic [4:0]         lanes_dec;
    logic               bw_legal;
    logic               start_acc;
    logic               accept;
    logic               a_last;
    logic               w_last;
    logic               drain_done;
    logic               cfg_err_q;
    logic [DRAIN_W-1:0] drain_cnt;

    always_comb begin
        lanes_dec = '0;
        bw_legal  = 1'b0;
        case (bitwidth)
            4'd1: begin lanes_dec = 5'd16; bw_legal = 1'b1; end
            4'd2: begin lanes_dec = 5'd8;  bw_legal = 1'b1; end
            4'd3: begin lanes_dec = 5'd4;  bw_legal = 1'b1; end
            default: ;
        endcase
    end

    assign start_acc  = (state == S_IDLE) && start && bw_legal && !reset;
    assign accept     = (state == S_ISSUE) && cc_ready;
    assign a_last     = (a_addr == num_a_q - CNT_W'(1));
    assign w_last     = (w_addr == num_w_q - CNT_W'(1));
    assign drain_done = (drain_cnt == DRAIN_W'(DRAIN_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cc_valid  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = start_acc;
                if (start_acc) begin
                    if ((num_w_chunks == '0) || (num_a_chunks == '0)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cc_valid = 1'b1;
                busy     = 1'b1;
                if (accept && a_last && w_last) begin
                    state_nxt = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state != S_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    // Config is captured only on an accepted start; addresses advance only on accept,
    // so everything presented stays put while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_w_q   <= '0;
            num_a_q   <= '0;
            lanes_q   <= '0;
            w_addr    <= '0;
            a_addr    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                cfg_err_q <= !bw_legal;
            end
            if (start_acc) begin
                num_w_q <= num_w_chunks;
                num_a_q <= num_a_chunks;
                lanes_q <= lanes_dec;
                w_addr  <= '0;
                a_addr  <= '0;
            end else if (accept) begin
                if (a_last) begin
                    a_addr <= '0;
                    w_addr <= w_last ? '0 : w_addr + CNT_W'(1);
                end else begin
                    a_addr <= a_addr + CNT_W'(1);
                end
            end
        end
    end

    assign cc_w_addr    = w_addr;
    assign cc_a_addr    = a_addr;
    assign cc_lanes     = lanes_q;
    assign cfg_err      = cfg_err_q;
    assign cc_w_restart = cc_valid && (w_addr == '0) && (a_addr == '0);
    assign cc_a_restart = cc_valid && (a_addr == '0);

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            stall_q <= '0;
        end else if (cc_valid && !cc_ready && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_coord_pair_scheduler.sv
// Self-checking bench for coord_pair_scheduler: queue-based tile model checked every
// cycle, plus directed tiles with literal expectations.
module tb_coord_pair_scheduler;

    localparam int CNT_W    = 16;
    localparam int PIPE_LAT = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       bitwidth;
    logic [CNT_W-1:0] num_w_chunks;
    logic [CNT_W-1:0] num_a_chunks;
    logic             cc_ready;
    logic             cc_valid;
    logic [CNT_W-1:0] cc_w_addr;
    logic [CNT_W-1:0] cc_a_addr;
    logic [4:0]       cc_lanes;
    logic             cc_w_restart;
    logic             cc_a_restart;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [31:0]      stall_cycles;

    coord_pair_scheduler #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bitwidth     (bitwidth),
        .num_w_chunks (num_w_chunks),
        .num_a_chunks (num_a_chunks),
        .cc_ready     (cc_ready),
        .cc_valid     (cc_valid),
        .cc_w_addr    (cc_w_addr),
        .cc_a_addr    (cc_a_addr),
        .cc_lanes     (cc_lanes),
        .cc_w_restart (cc_w_restart),
        .cc_a_restart (cc_a_restart),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tile model: a queue of pairs still to be issued plus a tail countdown to done.
    bit          m_active = 1'b0;
    int          m_tail   = 0;
    logic [31:0] mq[$];
    logic [4:0]  m_lanes  = '0;
    bit          m_err    = 1'b0;
    logic [31:0] m_stall  = '0;
    bit          chk_en   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            mq.delete();
            m_tail  = 0;
            m_lanes = '0;
            m_err   = 1'b0;
            m_stall = '0;
        end else if (!m_active) begin
            if (start) begin
                if (bitwidth >= 4'd1 && bitwidth <= 4'd3) begin
                    m_err   = 1'b0;
                    m_lanes = 5'(16 >> (bitwidth - 1));
                    m_stall = '0;
                    for (int w = 0; w < int'(num_w_chunks); w++)
                        for (int a = 0; a < int'(num_a_chunks); a++)
                            mq.push_back({16'(w), 16'(a)});
                    m_active = 1'b1;
                    m_tail   = (mq.size() == 0) ? 1 : 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (mq.size() > 0) begin
            if (cc_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_tail = PIPE_LAT + 1;
            end else if (m_stall != 32'hFFFF_FFFF) begin
                m_stall = m_stall + 1;
            end
        end else begin
            m_tail = m_tail - 1;
            if (m_tail == 0) m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        ev;
            logic        eb;
            logic [31:0] es;
            ev = (mq.size() > 0);
            eb = m_active || (!reset && start && bitwidth >= 4'd1 && bitwidth <= 4'd3);
`ifdef SCHED_PERF_CNT_EN
            es = m_stall;
`else
            es = '0;
`endif
            check("cc_valid", 32'(cc_valid), 32'(ev));
            if (ev) begin
                check("cc_w_addr", 32'(cc_w_addr), 32'(mq[0][31:16]));
                check("cc_a_addr", 32'(cc_a_addr), 32'(mq[0][15:0]));
                check("cc_w_restart", 32'(cc_w_restart), 32'(mq[0] == 32'h0));
                check("cc_a_restart", 32'(cc_a_restart), 32'(mq[0][15:0] == 16'h0));
            end else begin
                check("cc_w_restart_idle", 32'(cc_w_restart), 32'h0);
                check("cc_a_restart_idle", 32'(cc_a_restart), 32'h0);
            end
            check("busy", 32'(busy), 32'(eb));
            check("done", 32'(done), 32'(m_active && mq.size() == 0 && m_tail == 1));
            check("cc_lanes", 32'(cc_lanes), 32'(m_lanes));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
            check("stall_cycles", stall_cycles, es);
        end
    end

    // Observation log: only this block writes these.
    int          cyc = 0;
    logic [31:0] plog[$];
    int          done_total  = 0;
    int          done_cyc    = 0;
    int          busy_total  = 0;
    int          valid_total = 0;
    int          rst_total   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cc_valid && cc_ready) plog.push_back({cc_w_addr, cc_a_addr});
        if (done) begin
            done_total = done_total + 1;
            done_cyc   = cyc;
        end
        if (busy) busy_total = busy_total + 1;
        if (cc_valid) valid_total = valid_total + 1;
        if (cc_w_restart || cc_a_restart) rst_total = rst_total + 1;
    end

    int start_cyc;
    int d0, l0, b0, v0, r0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        d0 = done_total;
        l0 = plog.size();
        b0 = busy_total;
        v0 = valid_total;
        r0 = rst_total;
    endtask

    task automatic pulse_start(input logic [3:0] bw, input int w, input int a);
        bitwidth     = bw;
        num_w_chunks = 16'(w);
        num_a_chunks = 16'(a);
        start        = 1'b1;
        start_cyc    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (done_total != d0) break;
        end
        check(name, 32'(done_total - d0), 32'd1);
    endtask

    task automatic check_pairs(input string name, input logic [31:0] exp[$]);
        check({name, "_count"}, 32'(plog.size() - l0), 32'(exp.size()));
        for (int k = 0; k < exp.size() && (l0 + k) < plog.size(); k++)
            check(name, plog[l0 + k], exp[k]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];
        reset        = 1'b1;
        start        = 1'b0;
        bitwidth     = 4'd1;
        num_w_chunks = '0;
        num_a_chunks = '0;
        cc_ready     = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("reset_valid", 32'(cc_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_lanes", 32'(cc_lanes), 32'h0);
        check("reset_cfg_err", 32'(cfg_err), 32'h0);
        check("reset_stall", stall_cycles, 32'h0);

        // Tile 1: 16 lanes, 2x3 pairs, continuous ready.
        snap();
        pulse_start(4'd1, 2, 3);
        wait_done("t1_done", 50);
        check("t1_done_cycle", 32'(done_cyc - start_cyc + 1), 32'd9);
        check("t1_lanes", 32'(cc_lanes), 32'd16);
        tick();
        check("t1_busy_cycles", 32'(busy_total - b0), 32'd9);
        exp_q = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                  32'h0001_0000, 32'h0001_0001, 32'h0001_0002};
        check_pairs("t1_pair", exp_q);

        // Tile 2: 8 lanes, consumer stalls 3 cycles on pair (0,1).
        snap();
        pulse_start(4'd2, 1, 2);
        tick();
        cc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_a", 32'(cc_a_addr), 32'd1);
            tick();
        end
        cc_ready = 1'b1;
        wait_done("t2_done", 50);
        check("t2_lanes", 32'(cc_lanes), 32'd8);
        tick();
`ifdef SCHED_PERF_CNT_EN
        check("t2_stall", stall_cycles, 32'd3);
`else
        check("t2_stall", stall_cycles, 32'd0);
`endif
        exp_q = '{32'h0000_0000, 32'h0000_0001};
        check_pairs("t2_pair", exp_q);

        // Illegal bitwidth, then a legal 4-lane tile clears the error.
        snap();
        pulse_start(4'd5, 1, 1);
        check("t3_cfg_err_set", 32'(cfg_err), 32'd1);
        tick();
        tick();
        check("t3_no_busy", 32'(busy_total - b0), 32'd0);
        check("t3_no_valid", 32'(valid_total - v0), 32'd0);
        snap();
        pulse_start(4'd3, 1, 1);
        wait_done("t3_done", 50);
        tick();
        check("t3_cfg_err_clr", 32'(cfg_err), 32'd0);
        check("t3_lanes", 32'(cc_lanes), 32'd4);

        // Empty tile: no pairs, straight to done.
        snap();
        pulse_start(4'd1, 4, 0);
        wait_done("t4_done", 20);
        tick();
        tick();
        check("t4_busy_cycles", 32'(busy_total - b0), 32'd2);
        check("t4_no_valid", 32'(valid_total - v0), 32'd0);
        check("t4_no_restart", 32'(rst_total - r0), 32'd0);

        // Reset while presenting pair (1,0).
        snap();
        pulse_start(4'd1, 2, 2);
        tick();
        tick();
        check("t5_at_w", 32'(cc_w_addr), 32'd1);
        check("t5_at_a", 32'(cc_a_addr), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_valid", 32'(cc_valid), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_done", 32'(done), 32'h0);
        check("t5_rst_w", 32'(cc_w_addr), 32'h0);
        check("t5_rst_a", 32'(cc_a_addr), 32'h0);
        check("t5_rst_lanes", 32'(cc_lanes), 32'h0);
        check("t5_rst_stall", stall_cycles, 32'h0);
        tick();
        tick();
        check("t5_no_done", 32'(done_total - d0), 32'd0);
        snap();
        pulse_start(4'd1, 2, 2);
        check("t5_first_valid", 32'(cc_valid), 32'd1);
        check("t5_first_w_restart", 32'(cc_w_restart), 32'd1);
        wait_done("t5_done", 50);
        tick();
        exp_q = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0001_0001};
        check_pairs("t5_pair", exp_q);

        // Starts and config changes while busy, and a start in the done cycle.
        snap();
        pulse_start(4'd1, 2, 2);
        num_w_chunks = 16'd5;
        num_a_chunks = 16'd7;
        bitwidth     = 4'd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_done", 50);
        start        = 1'b1;
        num_w_chunks = 16'd1;
        num_a_chunks = 16'd1;
        bitwidth     = 4'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6_lanes", 32'(cc_lanes), 32'd16);
        check("t6_busy_cycles", 32'(busy_total - b0), 32'd7);
        check("t6_done_count", 32'(done_total - d0), 32'd1);
        check_pairs("t6_pair", exp_q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
